// File: rtl/csa_ctrl_pkg.sv
// Shared types for the carry-save accumulator controller.
// State encoding and resolve slice width.
package csa_ctrl_pkg;

  localparam int SLICE = 4;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    RESOLVE,
    DONE
  } state_t;

endpackage

// File: rtl/csa_compress_3to2.sv
// Bitwise 3:2 carry-save compressor.
// Carry vector is returned unshifted; the caller aligns it.
module csa_compress_3to2 #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] co
);

  assign s  = a ^ b ^ c;
  assign co = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/csa_accum_ctrl.sv
// Multi-operand accumulator: carry-save per beat,
// then a sliced carry-propagate resolve pass.
module csa_accum_ctrl
  import csa_ctrl_pkg::*;
#(
  parameter int W     = 12,
  parameter int CNT_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       in_data,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W+CNT_W-1:0] out_sum,
  output logic [CNT_W:0]     out_count,
  output logic               out_ovf
);

  localparam int AW  = W + CNT_W;
  localparam int NSL = AW / SLICE;
  localparam int KW  = $clog2(NSL + 1);

  if (AW % SLICE != 0) begin : g_bad_width
    $error("csa_accum_ctrl: W+CNT_W must be a multiple of 4");
  end

  state_t          state_q, state_d;
  logic [AW-1:0]   s_q, s_d;
  logic [AW-1:0]   c_q, c_d;
  logic [AW-1:0]   r_q, r_d;
  logic            cy_q, cy_d;
  logic [KW-1:0]   k_q, k_d;
  logic [CNT_W:0]  cnt_q, cnt_d;
  logic            ovf_q, ovf_d;

  logic [AW-1:0]   x;
  logic [AW-1:0]   cs_s;
  logic [AW-1:0]   cs_c;
  logic [AW-1:0]   cs_c_sh;
  logic            accept;
  logic [SLICE-1:0] s4, c4;
  logic [SLICE:0]  sum5;

  assign x = {{CNT_W{1'b0}}, in_data};

  csa_compress_3to2 #(
    .WIDTH(AW)
  ) u_csa (
    .a (s_q),
    .b (c_q),
    .c (x),
    .s (cs_s),
    .co(cs_c)
  );

  assign cs_c_sh = cs_c << 1;

  assign in_ready  = (state_q == IDLE) || (state_q == ACCUM);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign out_sum   = r_q;
  assign out_count = cnt_q;
  assign out_ovf   = ovf_q;

  always_comb begin
    s4 = '0;
    c4 = '0;
    for (int i = 0; i < NSL; i++) begin
      if (k_q == KW'(i)) begin
        s4 = s_q[i*SLICE +: SLICE];
        c4 = c_q[i*SLICE +: SLICE];
      end
    end
    sum5 = {1'b0, s4} + {1'b0, c4} + {{SLICE{1'b0}}, cy_q};
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    c_d     = c_q;
    r_d     = r_q;
    cy_d    = cy_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;

    if (accept) begin
      s_d = cs_s;
      c_d = cs_c_sh;
      if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
      if (cnt_q == (CNT_W+1)'(1 << CNT_W)) ovf_d = 1'b1;
    end

    unique case (state_q)
      IDLE, ACCUM: begin
        if (accept) state_d = in_last ? RESOLVE : ACCUM;
      end
      RESOLVE: begin
        // one trailing cycle after the top slice before DONE
        if (k_q == KW'(NSL)) begin
          state_d = DONE;
        end else begin
          for (int i = 0; i < NSL; i++) begin
            if (k_q == KW'(i)) r_d[i*SLICE +: SLICE] = sum5[SLICE-1:0];
          end
          cy_d = sum5[SLICE];
          k_d  = k_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          s_d     = '0;
          c_d     = '0;
          r_d     = '0;
          cy_d    = 1'b0;
          k_d     = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      s_q     <= '0;
      c_q     <= '0;
      r_q     <= '0;
      cy_q    <= 1'b0;
      k_q     <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      c_q     <= c_d;
      r_q     <= r_d;
      cy_q    <= cy_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule
